// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and synchroniser depth limits for input_debouncer
package debounce_pkg;
  localparam int DB_SYNC_MIN = 2;
  localparam int DB_SYNC_MAX = 4;
  typedef enum logic [1:0] {STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW} db_state_t;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: DEPTH-flop synchroniser for an asynchronous level, reset to 0
module sync_chain
  import debounce_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  if (DEPTH < DB_SYNC_MIN || DEPTH > DB_SYNC_MAX) begin : g_bad_depth
    $fatal(1, "sync_chain: DEPTH out of range");
  end
  logic [DEPTH-1:0] r_sync;
  // shift the raw level through the chain; only the last stage leaves this module
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[DEPTH-2:0], d};
  end
  assign q = r_sync[DEPTH-1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronise a raw level and accept changes stable for STABLE_CYCLES samples; rise/fall strobes only with INPUT_DEBOUNCER_EDGE_EN
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
    $fatal(1, "input_debouncer: STABLE_CYCLES out of range");
  end
  if (SYNC_STAGES < DB_SYNC_MIN || SYNC_STAGES > DB_SYNC_MAX) begin : g_bad_sync
    $fatal(1, "input_debouncer: SYNC_STAGES out of range");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic w_sync;
  db_state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic r_out;
  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (in),
    .q  (w_sync)
  );
  // next state and stability count; the count is zero in both stable states and never passes LAST
  always_comb begin
    w_state = r_state;
    w_cnt = '0;
    case (r_state)
      STABLE_LOW: if (w_sync) begin
        w_state = PEND_HIGH;
        w_cnt = ONE;
      end
      PEND_HIGH: if (!w_sync) w_state = STABLE_LOW;
        else if (r_cnt == LAST) w_state = STABLE_HIGH;
        else w_cnt = r_cnt + ONE;
      STABLE_HIGH: if (!w_sync) begin
        w_state = PEND_LOW;
        w_cnt = ONE;
      end
      PEND_LOW: if (w_sync) w_state = STABLE_HIGH;
        else if (r_cnt == LAST) w_state = STABLE_LOW;
        else w_cnt = r_cnt + ONE;
      default: w_state = STABLE_LOW;
    endcase
  end
  // state, count and debounced level; out is high whenever the accepted level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STABLE_LOW;
      r_cnt <= '0;
      r_out <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_out <= (w_state == STABLE_HIGH) || (w_state == PEND_LOW);
    end
  end
  assign out = r_out;
`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic r_rise, r_fall;
  // one-cycle strobes registered alongside out on each accepted transition
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= (r_state == PEND_HIGH) && (w_state == STABLE_HIGH);
      r_fall <= (r_state == PEND_LOW) && (w_state == STABLE_LOW);
    end
  end
  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of input_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2
module tb_input_debouncer;
  import debounce_pkg::*;
`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif
  logic clk, rst, in, out, rise, fall;
  int total = 0;
  int bad = 0;
  input_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out),
    .rise(rise),
    .fall(fall)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_out", out, 0);
      chk("rst_rise", rise, 0);
      chk("rst_fall", fall, 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("rel_out_e%0d", k), out, (k == 6) ? 8'd1 : 8'd0);
      chk($sformatf("rel_rise_e%0d", k), rise, (EDGE && k == 6) ? 8'd1 : 8'd0);
    end
    tick();
    chk("rel_rise_drop", rise, 0);
    chk("rel_out_hold", out, 1);
    in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("fall_out_e%0d", k), out, (k == 6) ? 8'd0 : 8'd1);
      chk($sformatf("fall_fall_e%0d", k), fall, (EDGE && k == 6) ? 8'd1 : 8'd0);
      chk($sformatf("fall_rise_e%0d", k), rise, 0);
    end
    tick();
    chk("fall_fall_drop", fall, 0);
    in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("step_out_e%0d", k), out, (k == 6) ? 8'd1 : 8'd0);
      chk($sformatf("step_rise_e%0d", k), rise, (EDGE && k == 6) ? 8'd1 : 8'd0);
      chk($sformatf("step_fall_e%0d", k), fall, 0);
    end
    tick();
    chk("step_rise_drop", rise, 0);
    in = 1'b0;
    repeat (7) tick();
    chk("pre_bounce_out", out, 0);
    for (int k = 0; k < 4; k++) begin
      in = ~k[0];
      tick();
      chk($sformatf("bounce_out_%0d", k), out, 0);
    end
    in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("bounce_out_e%0d", k), out, (k == 6) ? 8'd1 : 8'd0);
      chk($sformatf("bounce_rise_e%0d", k), rise, (EDGE && k == 6) ? 8'd1 : 8'd0);
    end
    in = 1'b0;
    repeat (7) tick();
    chk("pre_glitch_out", out, 0);
    in = 1'b1;
    repeat (3) tick();
    in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("glitch_out_%0d", k), out, 0);
      chk($sformatf("glitch_rise_%0d", k), rise, 0);
      tick();
    end
    in = 1'b1;
    repeat (4) tick();
    in = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      tick();
      chk($sformatf("pulse4_out_e%0d", k), out, (k >= 6 && k < 10) ? 8'd1 : 8'd0);
    end
    repeat (2) tick();
    in = 1'b1;
    repeat (4) tick();
    chk("pend_state", dut.r_state, PEND_HIGH);
    chk("pend_cnt", dut.r_cnt, 2);
    rst = 1'b1;
    tick();
    chk("midrst_state", dut.r_state, STABLE_LOW);
    chk("midrst_cnt", dut.r_cnt, 0);
    chk("midrst_out", out, 0);
    chk("midrst_rise", rise, 0);
    rst = 1'b0;
    in = 1'b0;
    repeat (8) tick();
    chk("end_out", out, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
